// File: rtl/rgb_cmp_pkg.sv
// rtl/rgb_cmp_pkg.sv - shared types, flag patterns and decode helper for the RGB comparator receiver
package rgb_cmp_pkg;

    typedef enum logic [1:0] {
        CMP_EQ  = 2'b00,
        CMP_GT  = 2'b01,
        CMP_LT  = 2'b10,
        CMP_ERR = 2'b11
    } cmp_code_t;

    typedef enum logic {
        ST_TRACK = 1'b0,
        ST_HOLD  = 1'b1
    } dec_state_t;

    // Flag order is {R, G, B} = {A>=B, A<=B, A!=B}
    localparam logic [2:0] PAT_EQ = 3'b110;
    localparam logic [2:0] PAT_GT = 3'b101;
    localparam logic [2:0] PAT_LT = 3'b011;

    function automatic cmp_code_t decode_flags(input logic [2:0] flags);
        cmp_code_t code;
        case (flags)
            PAT_EQ:  code = CMP_EQ;
            PAT_GT:  code = CMP_GT;
            PAT_LT:  code = CMP_LT;
            default: code = CMP_ERR;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/rgb_cmp_decoder_if.sv
// rtl/rgb_cmp_decoder_if.sv - flag inputs and result handshake of the RGB comparator receiver
interface rgb_cmp_decoder_if;
    import rgb_cmp_pkg::*;

    logic      r_in;
    logic      g_in;
    logic      b_in;
    logic      res_valid;
    logic      res_ready;
    cmp_code_t res_code;

    modport master (
        output r_in, g_in, b_in, res_ready,
        input  res_valid, res_code
    );

    modport slave (
        input  r_in, g_in, b_in, res_ready,
        output res_valid, res_code
    );

endinterface

// File: rtl/rgb_stab_filter.sv
// rtl/rgb_stab_filter.sv - N-cycle stability filter on a W-bit code
module rgb_stab_filter #(
    parameter int              N        = 4,
    parameter int              W        = 2,
    parameter logic [W-1:0]    RST_CODE = '1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] code,
    output logic [W-1:0] cand,
    output logic         stable
);

    localparam int          CW      = $clog2(N + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(N);

    logic [CW-1:0] stab_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cand     <= RST_CODE;
            stab_cnt <= '0;
        end else if (code == cand) begin
            if (stab_cnt != CNT_MAX) begin
                stab_cnt <= stab_cnt + CW'(1);
            end
        end else begin
            cand     <= code;
            stab_cnt <= CW'(1);
        end
    end

    assign stable = (stab_cnt == CNT_MAX);

endmodule

// File: rtl/rgb_cmp_decoder.sv
// rtl/rgb_cmp_decoder.sv - glitch-filtered decode of comparator RGB flags with result handshake and event counters
module rgb_cmp_decoder
    import rgb_cmp_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    rgb_cmp_decoder_if.slave bus,
    output logic [CNT_W-1:0] gt_cnt,
    output logic [CNT_W-1:0] lt_cnt,
    output logic [CNT_W-1:0] eq_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    logic [2:0] samp;
    cmp_code_t  dec;
    logic [1:0] cand_raw;
    cmp_code_t  cand;
    logic       stable;

    dec_state_t state;
    dec_state_t state_nx;
    cmp_code_t  res_code_q;
    cmp_code_t  last_code;
    logic       last_vld;
    logic       load;
    logic       accept;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            samp <= 3'b000;
        end else begin
            samp <= {bus.r_in, bus.g_in, bus.b_in};
        end
    end

    assign dec = decode_flags(samp);

    rgb_stab_filter #(
        .N        (STABLE_CYCLES),
        .W        (2),
        .RST_CODE (2'b11)
    ) u_filter (
        .clk    (clk),
        .rst    (rst),
        .code   (dec),
        .cand   (cand_raw),
        .stable (stable)
    );

    assign cand = cmp_code_t'(cand_raw);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_TRACK;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_TRACK: if (load)   state_nx = ST_HOLD;
            ST_HOLD:  if (accept) state_nx = ST_TRACK;
            default:  state_nx = ST_TRACK;
        endcase
    end

    // last_vld=0 acts as the invalid marker so the very first stable code is always emitted
    always_comb begin
        load          = 1'b0;
        accept        = 1'b0;
        bus.res_valid = 1'b0;
        case (state)
            ST_TRACK: load = stable && (!last_vld || (cand != last_code));
            ST_HOLD: begin
                bus.res_valid = 1'b1;
                accept        = bus.res_ready;
            end
            default: ;
        endcase
    end

    assign bus.res_code = res_code_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_code_q <= CMP_EQ;
            last_code  <= CMP_ERR;
            last_vld   <= 1'b0;
        end else if (load) begin
            res_code_q <= cand;
            last_code  <= cand;
            last_vld   <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gt_cnt  <= '0;
            lt_cnt  <= '0;
            eq_cnt  <= '0;
            err_cnt <= '0;
        end else if (accept) begin
            case (res_code_q)
                CMP_GT:  gt_cnt  <= sat_inc(gt_cnt);
                CMP_LT:  lt_cnt  <= sat_inc(lt_cnt);
                CMP_EQ:  eq_cnt  <= sat_inc(eq_cnt);
                default: err_cnt <= sat_inc(err_cnt);
            endcase
        end
    end

endmodule

// File: tb/tb_rgb_cmp_decoder.sv
// tb/tb_rgb_cmp_decoder.sv - directed self-checking bench for rgb_cmp_decoder
module tb_rgb_cmp_decoder;
    import rgb_cmp_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rgb_cmp_decoder_if ifa();
    rgb_cmp_decoder_if ifb();

    logic [7:0] gt_a, lt_a, eq_a, err_a;
    logic [1:0] gt_b, lt_b, eq_b, err_b;

    rgb_cmp_decoder #(.STABLE_CYCLES(4), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa),
        .gt_cnt(gt_a), .lt_cnt(lt_a), .eq_cnt(eq_a), .err_cnt(err_a)
    );

    rgb_cmp_decoder #(.STABLE_CYCLES(4), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb),
        .gt_cnt(gt_b), .lt_cnt(lt_b), .eq_cnt(eq_b), .err_cnt(err_b)
    );

    typedef struct {
        logic [1:0] a;
        logic [1:0] b;
        int         exp_code;
    } sweep_t;

    sweep_t tbl[16];
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic [2:0] f);
        {ifa.r_in, ifa.g_in, ifa.b_in} = f;
    endtask

    task automatic set_b(input logic [2:0] f);
        {ifb.r_in, ifb.g_in, ifb.b_in} = f;
    endtask

    task automatic wait_a(input string name, input int max, output int n);
        n = 0;
        for (int i = 1; i <= max && n == 0; i++) begin
            step();
            if (ifa.res_valid) n = i;
        end
        check($sformatf("%s_valid", name), int'(ifa.res_valid), 1);
    endtask

    task automatic wait_b(input string name, input int max, output int n);
        n = 0;
        for (int i = 1; i <= max && n == 0; i++) begin
            step();
            if (ifb.res_valid) n = i;
        end
        check($sformatf("%s_valid", name), int'(ifb.res_valid), 1);
    endtask

    initial begin
        int n;
        int extra;
        int codes[$];

        for (int i = 0; i < 16; i++) begin
            tbl[i].a        = 2'(i / 4);
            tbl[i].b        = 2'(i % 4);
            tbl[i].exp_code = (tbl[i].a == tbl[i].b) ? 0 : ((tbl[i].a > tbl[i].b) ? 1 : 2);
        end

        // reset held with random flags
        rst = 1'b1;
        ifa.res_ready = 1'b0;
        ifb.res_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_a(3'($urandom_range(0, 7)));
            set_b(3'($urandom_range(0, 7)));
            step();
        end
        check("rst_valid_a", int'(ifa.res_valid), 0);
        check("rst_code_a",  int'(ifa.res_code), 0);
        check("rst_gt_a",    int'(gt_a), 0);
        check("rst_lt_a",    int'(lt_a), 0);
        check("rst_eq_a",    int'(eq_a), 0);
        check("rst_err_a",   int'(err_a), 0);
        check("rst_valid_b", int'(ifb.res_valid), 0);
        check("rst_gt_b",    int'(gt_b), 0);

        // steady GT, latency and no re-emission
        set_a(3'b101);
        set_b(3'b000);
        ifa.res_ready = 1'b1;
        rst = 1'b0;
        wait_a("gt", 12, n);
        check("gt_latency", n, 6);
        check("gt_code", int'(ifa.res_code), 1);
        step();
        check("gt_accept_valid", int'(ifa.res_valid), 0);
        check("gt_cnt", int'(gt_a), 1);
        extra = 0;
        repeat (20) begin
            step();
            if (ifa.res_valid) extra++;
        end
        check("gt_no_repeat", extra, 0);

        // glitch shorter than the filter window
        set_a(3'b110);
        wait_a("eq", 12, n);
        check("eq_code", int'(ifa.res_code), 0);
        step();
        check("eq_cnt_1", int'(eq_a), 1);
        set_a(3'b011);
        repeat (3) step();
        set_a(3'b110);
        extra = 0;
        repeat (15) begin
            step();
            if (ifa.res_valid) extra++;
        end
        check("glitch_no_result", extra, 0);
        check("glitch_lt_cnt", int'(lt_a), 0);

        // backpressure: LT held while EQ becomes stable underneath
        ifa.res_ready = 1'b0;
        set_a(3'b011);
        wait_a("lt", 12, n);
        check("lt_code", int'(ifa.res_code), 2);
        set_a(3'b110);
        repeat (10) step();
        check("lt_held_code", int'(ifa.res_code), 2);
        check("lt_held_valid", int'(ifa.res_valid), 1);
        check("lt_held_cnt", int'(lt_a), 0);
        ifa.res_ready = 1'b1;
        step();
        check("lt_cnt", int'(lt_a), 1);
        check("gap_valid", int'(ifa.res_valid), 0);
        step();
        check("eq_follow_valid", int'(ifa.res_valid), 1);
        check("eq_follow_code", int'(ifa.res_code), 0);
        step();
        check("eq_cnt_2", int'(eq_a), 2);

        // asynchronous reset during HOLD discards the pending result
        ifa.res_ready = 1'b0;
        set_a(3'b101);
        wait_a("gt_hold", 12, n);
        check("gt_hold_code", int'(ifa.res_code), 1);
        #3;
        rst = 1'b1;
        #1;
        check("async_valid", int'(ifa.res_valid), 0);
        check("async_code", int'(ifa.res_code), 0);
        check("async_eq_cnt", int'(eq_a), 0);
        check("async_lt_cnt", int'(lt_a), 0);
        step();
        step();
        rst = 1'b0;
        ifa.res_ready = 1'b1;
        repeat (10) step();
        check("post_rst_gt_cnt", int'(gt_a), 1);
        check("post_rst_lt_cnt", int'(lt_a), 0);

        // consecutive invalid patterns give a single ERR, then GT
        foreach (codes[i]) codes.delete(i);
        for (int p = 0; p < 4; p++) begin
            case (p)
                0: set_a(3'b000);
                1: set_a(3'b111);
                2: set_a(3'b100);
                default: set_a(3'b101);
            endcase
            repeat ((p == 3) ? 12 : 6) begin
                step();
                if (ifa.res_valid) codes.push_back(int'(ifa.res_code));
            end
        end
        check("inv_result_count", codes.size(), 2);
        check("inv_first_code", (codes.size() > 0) ? codes[0] : -1, 3);
        check("inv_second_code", (codes.size() > 1) ? codes[1] : -1, 1);
        check("inv_err_cnt", int'(err_a), 1);
        check("inv_gt_cnt", int'(gt_a), 2);

        // 2-bit counters: alternate GT/EQ past saturation
        for (int k = 0; k < 7; k++) begin
            set_b((k % 2 == 0) ? 3'b101 : 3'b110);
            wait_b($sformatf("alt%0d", k), 12, n);
            check($sformatf("alt%0d_code", k), int'(ifb.res_code), (k % 2 == 0) ? 1 : 0);
            step();
        end
        check("sat_gt_cnt", int'(gt_b), 3);
        check("sat_eq_cnt", int'(eq_b), 3);
        check("sat_valid_drop", int'(ifb.res_valid), 0);

        // exhaustive A/B sweep through the comparator flag equations
        for (int i = 0; i < 16; i++) begin
            set_b(3'b111);
            repeat (8) step();
            set_b({tbl[i].a >= tbl[i].b, tbl[i].a <= tbl[i].b, tbl[i].a != tbl[i].b});
            wait_b($sformatf("sweep_a%0d_b%0d", tbl[i].a, tbl[i].b), 10, n);
            check($sformatf("sweep_a%0d_b%0d_code", tbl[i].a, tbl[i].b),
                  int'(ifb.res_code), tbl[i].exp_code);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
